// File: rtl/clkgen_prog_sequencer_pkg.sv
// Shared definitions for the DCM_CLKGEN programming sequencer.
// Contents: FSM state encoding, debug struct, frame constants, request
// legality check and frame word builder.
package clkgen_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_LOAD_D = 4'd1,
    ST_GAP1   = 4'd2,
    ST_LOAD_M = 4'd3,
    ST_GAP2   = 4'd4,
    ST_GO     = 4'd5,
    ST_WAIT   = 4'd6,
    ST_DONE   = 4'd7,
    ST_ERR    = 4'd8
  } state_t;

  // Observability bundle: FSM state, pending slot and prog_clk edge strobes.
  typedef struct packed {
    state_t state;
    logic   pend_valid;
    logic   prog_rise;
    logic   prog_fall;
  } dbg_t;

  // Command codes; bit0 goes out on PROGDATA first.
  localparam logic [1:0] CMD_LOAD_D = 2'b01;
  localparam logic [1:0] CMD_LOAD_M = 2'b11;

  localparam int         FRAME_BITS = 10;
  localparam logic [3:0] LAST_BIT   = 4'(FRAME_BITS - 1);

  localparam logic [7:0] M_MIN = 8'd2;
  localparam logic [7:0] D_MIN = 8'd1;

  // Upper bound 255 is implied by the 8-bit fields.
  function automatic logic req_legal(input logic [7:0] m, input logic [7:0] d);
    return (m >= M_MIN) && (d >= D_MIN);
  endfunction

  // Frame word shifted out LSB first: command bits, then value-1.
  function automatic logic [9:0] frame_word(input logic [1:0] cmd, input logic [7:0] v);
    return {v - 8'd1, cmd};
  endfunction

endpackage

// File: rtl/clkgen_prog_sequencer_if.sv
// Request/status interface between serial_decode and the sequencer.
//   multiplier, divider : requested M and D (binary)
//   change              : one-cycle valid strobe for multiplier/divider
//   busy                : sequencer owns an update
//   cfg_done, cfg_error : one-cycle completion / failure pulses
// Handshake: change is a valid with no ready. The sequencer always takes it,
// either starting at once (idle) or parking it in a one-deep pending slot
// where a later change overwrites an earlier one. Status is pulse-based.
interface clkgen_prog_sequencer_if;
  logic [7:0] multiplier;
  logic [7:0] divider;
  logic       change;
  logic       busy;
  logic       cfg_done;
  logic       cfg_error;

  modport master (
    output multiplier, divider, change,
    input  busy, cfg_done, cfg_error
  );

  modport slave (
    input  multiplier, divider, change,
    output busy, cfg_done, cfg_error
  );
endinterface

// File: rtl/clkgen_prog_sequencer_prog_clk_gen.sv
// Free-running PROGCLK divider: clk/(2*PROG_DIV).
//   clk, reset  : system clock, synchronous active-high reset
//   prog_clk_o  : divided clock, 0 after reset
//   rise_o      : high in the clk cycle whose edge raises prog_clk_o
//   fall_o      : high in the clk cycle whose edge lowers prog_clk_o
module prog_clk_gen #(
  parameter int PROG_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic prog_clk_o,
  output logic rise_o,
  output logic fall_o
);
  localparam int            CW       = (PROG_DIV > 1) ? $clog2(PROG_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PROG_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          pclk_q, pclk_d;
  logic          wrap;

  always_comb begin
    wrap   = (cnt_q == CNT_LAST);
    cnt_d  = wrap ? '0 : cnt_q + 1'b1;
    pclk_d = wrap ? ~pclk_q : pclk_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      pclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pclk_q <= pclk_d;
    end
  end

  assign prog_clk_o = pclk_q;
  assign rise_o     = wrap & ~pclk_q;
  assign fall_o     = wrap &  pclk_q;
endmodule

// File: rtl/clkgen_prog_sequencer.sv
// Converts an M/D update into the DCM_CLKGEN serial programming sequence
// (LOAD_D frame, gap, LOAD_M frame, gap, GO) and waits for PROGDONE.
//   clk, reset  : system clock, synchronous active-high reset
//   cfg         : request/status interface (slave side)
//   prog_done   : DCM PROGDONE, asynchronous
//   prog_clk    : DCM PROGCLK, clk/(2*PROG_DIV)
//   prog_en     : DCM PROGEN
//   prog_data   : DCM PROGDATA
//   dbg_o       : FSM state, pending flag and prog_clk strobes
module clkgen_prog_sequencer
  import clkgen_pkg::*;
#(
  parameter int PROG_DIV     = 4,
  parameter int DONE_TIMEOUT = 4095
) (
  input  logic                          clk,
  input  logic                          reset,
  clkgen_prog_sequencer_if.slave        cfg,
  input  logic                          prog_done,
  output logic                          prog_clk,
  output logic                          prog_en,
  output logic                          prog_data,
  output dbg_t                          dbg_o
);
  localparam logic [11:0] TO_LIMIT = 12'(DONE_TIMEOUT);

  logic       tick, tick_rise, pclk;

  logic       done_meta_q, done_sync_q;
  state_t     state_q;
  logic [7:0] m_q;
  logic       pend_valid_q;
  logic [7:0] pend_m_q, pend_d_q;
  logic [9:0] shreg_q;
  logic [3:0] bit_cnt_q;
  logic [11:0] to_cnt_q;
  logic       prog_en_q, prog_data_q;
  logic       busy_q, cfg_done_q, cfg_error_q;

  logic       accept;
  logic [7:0] acc_m, acc_d;

  prog_clk_gen #(.PROG_DIV(PROG_DIV)) u_prog_clk_gen (
    .clk        (clk),
    .reset      (reset),
    .prog_clk_o (pclk),
    .rise_o     (tick_rise),
    .fall_o     (tick)
  );

  // A fresh change beats the pending slot when both are present in IDLE.
  always_comb begin
    accept = (state_q == ST_IDLE) && (cfg.change || pend_valid_q);
    acc_m  = cfg.change ? cfg.multiplier : pend_m_q;
    acc_d  = cfg.change ? cfg.divider    : pend_d_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      done_meta_q  <= 1'b0;
      done_sync_q  <= 1'b0;
      state_q      <= ST_IDLE;
      m_q          <= '0;
      pend_valid_q <= 1'b0;
      pend_m_q     <= '0;
      pend_d_q     <= '0;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      to_cnt_q     <= '0;
      prog_en_q    <= 1'b0;
      prog_data_q  <= 1'b0;
      busy_q       <= 1'b0;
      cfg_done_q   <= 1'b0;
      cfg_error_q  <= 1'b0;
    end else begin
      done_meta_q <= prog_done;
      done_sync_q <= done_meta_q;
      cfg_done_q  <= 1'b0;
      cfg_error_q <= 1'b0;

      // Any change outside IDLE (including the DONE/ERR exit cycle) is parked.
      if (cfg.change && (state_q != ST_IDLE)) begin
        pend_valid_q <= 1'b1;
        pend_m_q     <= cfg.multiplier;
        pend_d_q     <= cfg.divider;
      end else if (accept) begin
        pend_valid_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            busy_q <= 1'b1;
            if (req_legal(acc_m, acc_d)) begin
              m_q       <= acc_m;
              shreg_q   <= frame_word(CMD_LOAD_D, acc_d);
              bit_cnt_q <= '0;
              state_q   <= ST_LOAD_D;
            end else begin
              cfg_error_q <= 1'b1;
              state_q     <= ST_ERR;
            end
          end else begin
            busy_q <= 1'b0;
          end
        end

        ST_LOAD_D, ST_LOAD_M: begin
          if (tick) begin
            prog_en_q   <= 1'b1;
            prog_data_q <= shreg_q[0];
            shreg_q     <= {1'b0, shreg_q[9:1]};
            bit_cnt_q   <= bit_cnt_q + 4'd1;
            if (bit_cnt_q == LAST_BIT)
              state_q <= (state_q == ST_LOAD_D) ? ST_GAP1 : ST_GAP2;
          end
        end

        ST_GAP1: begin
          if (tick) begin
            prog_en_q   <= 1'b0;
            prog_data_q <= 1'b0;
            shreg_q     <= frame_word(CMD_LOAD_M, m_q);
            bit_cnt_q   <= '0;
            state_q     <= ST_LOAD_M;
          end
        end

        ST_GAP2: begin
          if (tick) begin
            prog_en_q   <= 1'b0;
            prog_data_q <= 1'b0;
            state_q     <= ST_GO;
          end
        end

        ST_GO: begin
          if (tick) begin
            prog_en_q   <= 1'b1;
            prog_data_q <= 1'b0;
            to_cnt_q    <= '0;
            state_q     <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (tick) prog_en_q <= 1'b0;
          // Only act once the GO tick has finished, so PROGEN never
          // drops outside a fall strobe.
          if (!prog_en_q) begin
            if (done_sync_q) begin
              cfg_done_q <= 1'b1;
              state_q    <= ST_DONE;
            end else if (to_cnt_q == TO_LIMIT) begin
              cfg_error_q <= 1'b1;
              state_q     <= ST_ERR;
            end
          end
          if (tick && (to_cnt_q != 12'hFFF)) to_cnt_q <= to_cnt_q + 12'd1;
        end

        ST_DONE, ST_ERR: begin
          // Keep busy up if another update will start on the next IDLE cycle.
          busy_q  <= pend_valid_q || cfg.change;
          state_q <= ST_IDLE;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign prog_clk      = pclk;
  assign prog_en       = prog_en_q;
  assign prog_data     = prog_data_q;
  assign cfg.busy      = busy_q;
  assign cfg.cfg_done  = cfg_done_q;
  assign cfg.cfg_error = cfg_error_q;
  assign dbg_o         = '{state: state_q, pend_valid: pend_valid_q,
                           prog_rise: tick_rise, prog_fall: tick};
endmodule
